// File: rtl/matrix_feed_controller.sv
// Buffers one convolution's kernel+pixel words from the host, streams them into the
// accelerator FIFO, starts the convolution and captures its result with a bounded wait.
module matrix_feed_controller #(
  parameter int unsigned BIT_LENGTH     = 32,
  parameter int unsigned WORD_COUNT     = 18,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  loadValid,
  input  logic [BIT_LENGTH-1:0] loadData,
  output logic                  loadReady,
  input  logic                  go,
  output logic                  busy,
  output logic                  fifoWrite,
  output logic [BIT_LENGTH-1:0] fifoData,
  input  logic                  FULL,
  output logic                  cStart,
  input  logic                  cReady,
  input  logic [BIT_LENGTH-1:0] finalsum,
  output logic [BIT_LENGTH-1:0] result,
  output logic                  done,
  output logic                  timeout
);

  localparam int unsigned PTR_W = $clog2(WORD_COUNT + 1);
  localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(WORD_COUNT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORD_COUNT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, STREAM, START, WAIT} state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      wait_cnt;
  logic [BIT_LENGTH-1:0] buffer [WORD_COUNT];
  logic                  load_accept, capture, abort;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; fifoWrite/cStart are gated by Rst so an abort is immediate
  always_comb begin
    state_nxt   = state;
    load_accept = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    loadReady   = 1'b0;
    busy        = 1'b1;
    fifoWrite   = 1'b0;
    fifoData    = '0;
    cStart      = 1'b0;
    case (state)
      LOAD: begin
        busy      = 1'b0;
        loadReady = (wr_ptr < FULL_PTR);
        if (go && (wr_ptr == FULL_PTR)) state_nxt = STREAM;
        else if (loadValid && (wr_ptr < FULL_PTR)) load_accept = 1'b1;
      end
      STREAM: begin
        fifoWrite = !FULL && !Rst;
        fifoData  = buffer[IDX_W'(rd_ptr)];
        if (!FULL && (rd_ptr == LAST_PTR)) state_nxt = START;
      end
      START: begin
        cStart    = !Rst;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cReady) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end else if (wait_cnt == LAST_CNT) begin
          abort     = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Word buffer; contents need no reset
  always_ff @(posedge Clk) begin
    if (load_accept) buffer[IDX_W'(wr_ptr)] <= loadData;
  end

  // Pointers, wait counter, result capture and completion pulses
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wait_cnt <= '0;
      result   <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done    <= capture;
      timeout <= abort;
      if (load_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if ((state == STREAM) && fifoWrite) rd_ptr <= rd_ptr + PTR_W'(1);
      if (state == START) wait_cnt <= '0;
      else if ((state == WAIT) && !cReady) wait_cnt <= wait_cnt + CNT_W'(1);
      if (capture) result <= finalsum;
      if (capture || abort) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_feed_controller.sv
// Directed and randomized checks of matrix_feed_controller against a queue-based
// model of the load / stream / start / wait sequence.
module tb_matrix_feed_controller;

  localparam int unsigned BL = 32;
  localparam int unsigned WC = 18;
  localparam int unsigned TO = 1023;

  logic          Clk = 1'b0;
  logic          Rst, loadValid, go, FULL, cReady;
  logic [BL-1:0] loadData, finalsum;
  logic          loadReady, busy, fifoWrite, cStart, done, timeout;
  logic [BL-1:0] fifoData, result;

  matrix_feed_controller #(.BIT_LENGTH(BL), .WORD_COUNT(WC), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst(Rst), .loadValid(loadValid), .loadData(loadData), .loadReady(loadReady),
    .go(go), .busy(busy), .fifoWrite(fifoWrite), .fifoData(fifoData), .FULL(FULL),
    .cStart(cStart), .cReady(cReady), .finalsum(finalsum), .result(result),
    .done(done), .timeout(timeout)
  );

  always #5 Clk = ~Clk;

  int            n_pass = 0;
  int            n_chk  = 0;
  logic [BL-1:0] exp_q[$];
  logic [BL-1:0] exp_result;

  task automatic chk(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; loadValid = 1'b0; go = 1'b0; FULL = 1'b0; cReady = 1'b0;
    loadData = '0; finalsum = '0;
    tick(); tick();
    Rst = 1'b0;
    exp_q.delete();
    exp_result = '0;
    #1;
    chk("rst_load_ready", loadReady, 1);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_fifo_write", fifoWrite, 0);
    chk("rst_cstart", cStart, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
  endtask

  // Offer n words; sequential data numbers words from 1 in load order
  task automatic load_words(input int n, input bit gaps, input bit seq);
    logic [BL-1:0] w;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        loadValid = 1'b0;
        tick();
      end
      w = seq ? BL'(exp_q.size() + 1) : BL'($urandom);
      loadValid = 1'b1;
      loadData  = w;
      #1;
      chk("load_ready", loadReady, (exp_q.size() < WC) ? 1 : 0);
      if (exp_q.size() < WC) exp_q.push_back(w);
      tick();
    end
    loadValid = 1'b0;
  endtask

  // mode 0: FULL low, 1: FULL high on stream cycles 3..6, 2: random FULL
  task automatic run_stream(input int mode, input bit issue_go);
    int idx = 0;
    int c   = 0;
    if (issue_go) begin
      go = 1'b1;
      #1;
      chk("go_busy", busy, 0);
      tick();
      go = 1'b0;
    end
    while (idx < WC && c < 500) begin
      case (mode)
        1:       FULL = (c >= 2 && c <= 5);
        2:       FULL = ($urandom_range(0, 2) == 0);
        default: FULL = 1'b0;
      endcase
      #1;
      chk("fifo_write", fifoWrite, FULL ? 0 : 1);
      chk("fifo_data", fifoData, exp_q[idx]);
      chk("cstart_early", cStart, 0);
      if (fifoWrite === 1'b1) idx++;
      tick();
      c++;
    end
    FULL = 1'b0;
    if (idx < WC) chk("stream_budget", BL'(idx), BL'(WC));
    #1;
    chk("cstart", cStart, 1);
    chk("start_busy", busy, 1);
    chk("start_fifo_write", fifoWrite, 0);
    tick();
    exp_q.delete();
  endtask

  // cReady arrives after `delay` WAIT cycles
  task automatic wait_done(input int delay, input logic [BL-1:0] fs);
    for (int k = 0; k < delay; k++) begin
      cReady = 1'b0;
      #1;
      chk("wait_done_low", done, 0);
      chk("wait_busy", busy, 1);
      chk("wait_cstart", cStart, 0);
      tick();
    end
    cReady = 1'b1;
    finalsum = fs;
    tick();
    cReady = 1'b0;
    finalsum = BL'($urandom);
    exp_result = fs;
    #1;
    chk("done_pulse", done, 1);
    chk("result", result, exp_result);
    chk("done_load_ready", loadReady, 1);
    chk("done_busy", busy, 0);
    tick();
    chk("done_single", done, 0);
    chk("result_hold", result, exp_result);
  endtask

  task automatic wait_timeout();
    cReady = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      if (timeout !== 1'b0 || busy !== 1'b1) begin
        chk("timeout_early", timeout, 0);
        chk("timeout_busy", busy, 1);
      end
      tick();
    end
    chk("timeout_pulse", timeout, 1);
    chk("timeout_result", result, exp_result);
    chk("timeout_done", done, 0);
    chk("timeout_load_ready", loadReady, 1);
    tick();
    chk("timeout_single", timeout, 0);
    chk("timeout_load_ready_next", loadReady, 1);
  endtask

  initial begin
    Rst = 1'b1;
    do_reset();

    // Plain run with data 1..18 and result 0xAB
    load_words(WC, 1'b0, 1'b1);
    run_stream(0, 1'b1);
    wait_done(5, 32'h0000_00AB);

    // Back-pressure on stream cycles 3..6
    load_words(WC, 1'b0, 1'b1);
    run_stream(1, 1'b1);
    wait_done(3, BL'($urandom));

    // go on a partial buffer is ignored
    load_words(10, 1'b0, 1'b1);
    go = 1'b1;
    tick();
    go = 1'b0;
    #1;
    chk("partial_go_busy", busy, 0);
    chk("partial_go_ready", loadReady, 1);
    load_words(8, 1'b0, 1'b1);
    run_stream(0, 1'b1);
    wait_done(2, BL'($urandom));

    // No cReady: abort after the wait limit, then cReady outside WAIT is ignored
    load_words(WC, 1'b1, 1'b0);
    run_stream(0, 1'b1);
    wait_timeout();
    cReady = 1'b1;
    finalsum = 32'h5555_5555;
    tick(); tick();
    cReady = 1'b0;
    chk("idle_cready_result", result, exp_result);
    chk("idle_cready_done", done, 0);
    chk("idle_cready_busy", busy, 0);

    // Reset in the middle of streaming
    load_words(WC, 1'b0, 1'b1);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("pre_rst_data", fifoData, exp_q[i]);
      tick();
    end
    Rst = 1'b1;
    #1;
    chk("mid_rst_fifo_write", fifoWrite, 0);
    tick();
    Rst = 1'b0;
    exp_q.delete();
    exp_result = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_fifo_write", fifoWrite, 0);
      chk("post_rst_cstart", cStart, 0);
      chk("post_rst_result", result, 0);
      chk("post_rst_ready", loadReady, 1);
      tick();
    end
    load_words(WC, 1'b0, 1'b1);
    run_stream(0, 1'b1);
    wait_done(1, BL'($urandom));

    // go and loadValid together on a full buffer: the extra word is dropped
    load_words(WC, 1'b0, 1'b0);
    go = 1'b1;
    loadValid = 1'b1;
    loadData = 32'hDEAD_BEEF;
    #1;
    chk("go_valid_ready", loadReady, 0);
    tick();
    go = 1'b0;
    loadValid = 1'b0;
    chk("go_valid_busy", busy, 1);
    run_stream(0, 1'b0);
    wait_done(4, BL'($urandom));

    // Randomized runs, including a word offered to a full buffer
    for (int r = 0; r < 4; r++) begin
      load_words(WC + 1, 1'b1, 1'b0);
      run_stream(2, 1'b1);
      wait_done(int'($urandom_range(0, 20)), BL'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/matrix_feed_controller.md
MATRIX_FEED_CONTROLLER -- requirements
Module: matrix_feed_controller

Interface
REQ-001 SHALL have parameter BIT_LENGTH, default 32: width of every data word.
REQ-002 SHALL have parameter WORD_COUNT, default 18: words per convolution (9 kernel followed by 9 pixel).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum WAIT-state cycles before abort.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port Clk, input, 1: clock; all logic on rising edge.
REQ-006 SHALL have port Rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port loadValid, input, 1: host word strobe.
REQ-008 SHALL have port loadData, input, BIT_LENGTH: host word.
REQ-009 SHALL have port loadReady, output, 1: buffer accepts words.
REQ-010 SHALL have port go, input, 1: host request to run one convolution.
REQ-011 SHALL have port busy, output, 1: high in every state except LOAD.
REQ-012 SHALL have port fifoWrite, output, 1: write strobe to the accelerator input FIFO.
REQ-013 SHALL have port fifoData, output, BIT_LENGTH: FIFO write data.
REQ-014 SHALL have port FULL, input, 1: accelerator FIFO full flag.
REQ-015 SHALL have port cStart, output, 1: convolution start pulse.
REQ-016 SHALL have port cReady, input, 1: accelerator result valid.
REQ-017 SHALL have port finalsum, input, BIT_LENGTH: accelerator result.
REQ-018 SHALL have port result, output, BIT_LENGTH: last captured result.
REQ-019 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-020 SHALL have port timeout, output, 1: one-cycle abort pulse.

Function
REQ-021 SHALL implement FSM states LOAD, STREAM, START, WAIT; busy = (state != LOAD).
REQ-022 SHALL, in LOAD, store loadData into buffer[wrPtr] and increment wrPtr on each cycle with loadValid=1 and wrPtr<WORD_COUNT.
REQ-023 SHALL drive loadReady = (state==LOAD) and (wrPtr<WORD_COUNT); loadValid at wrPtr==WORD_COUNT is ignored with no buffer change.
REQ-024 SHALL move LOAD->STREAM on go=1 only when wrPtr==WORD_COUNT; go with a partial buffer, or go in any other state, is ignored.
REQ-025 SHALL give go priority over loadValid in the same cycle; that loadValid is dropped.
REQ-026 SHALL, in STREAM, drive fifoWrite = not FULL combinationally and fifoData = buffer[rdPtr]; rdPtr increments only on cycles with fifoWrite=1.
REQ-027 SHALL hold rdPtr and fifoData stable while FULL=1; no word is skipped or duplicated.
REQ-028 SHALL move STREAM->START on the cycle the word at rdPtr=WORD_COUNT-1 is written; words leave in load order.
REQ-029 SHALL drive cStart=1 for exactly the single START cycle, then enter WAIT with waitCnt=0.
REQ-030 SHALL, in WAIT, increment waitCnt each cycle with cReady=0.
REQ-031 SHALL, on cReady=1 in WAIT, register finalsum into result, pulse done for one cycle, clear wrPtr/rdPtr and return to LOAD.
REQ-032 SHALL, when waitCnt reaches TIMEOUT_CYCLES with cReady=0, pulse timeout for one cycle, keep result unchanged, clear pointers and return to LOAD.
REQ-033 SHALL give cReady priority over timeout in the same cycle.
REQ-034 SHALL hold result until the next successful capture.
REQ-035 SHALL ignore cReady outside WAIT.
REQ-036 SHALL size pointers to hold WORD_COUNT and waitCnt to hold TIMEOUT_CYCLES, with no wrap-around.

Reset
REQ-037 SHALL, while Rst=1 at a rising edge: state=LOAD, wrPtr=rdPtr=waitCnt=0, result=0, and fifoWrite, cStart, done, timeout all 0.
REQ-038 SHALL abort any in-progress operation on mid-operation Rst with no further fifoWrite or cStart; buffer contents are don't-care.
REQ-039 SHALL assert loadReady=1 on the first cycle after Rst deasserts.

Verification
REQ-040 Bench SHALL cover: load words 1..18, go, FULL=0 -> 18 consecutive fifoWrite with data 1..18, one cStart, cReady after 5 cycles with finalsum=0x0000_00AB -> result=0xAB and done pulses once.
REQ-041 Bench SHALL cover: FULL=1 for cycles 3-6 of STREAM -> fifoWrite=0 in those cycles, data sequence still 1..18 with no gaps or repeats.
REQ-042 Bench SHALL cover: go after only 10 words -> no state change; 8 more words then go -> normal run.
REQ-043 Bench SHALL cover: cReady never asserted -> timeout pulses exactly 1023 cycles after WAIT entry, result keeps its prior value, loadReady=1 next cycle.
REQ-044 Bench SHALL cover: Rst pulsed at word 7 of STREAM -> fifoWrite=0 immediately, no cStart, result=0, new load accepted.
REQ-045 Bench SHALL cover: loadValid with go in the same cycle on a full buffer -> STREAM entered and the extra word is dropped.
